// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
//
// Purpose: executes MULT/MULTU/DIV/DIVU one bit per cycle and MTHI/MTLO in a single
// cycle. Signed operations work on magnitudes, and the signs are restored when HI/LO
// are written.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start, op    request and opcode (000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO)
//   src_a, src_b rs / rt operands
//   cancel       abort a running MULT/DIV without writing HI/LO
//   busy, done   in-flight flag and one-cycle completion pulse
//   div_by_zero  sticky divide-by-zero flag
//   hi, lo       architectural HI/LO registers
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide: {partial remainder, quotient/dividend bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;         // divide by zero pending, finishes at E1
  logic               neg_q, neg_d;       // negate product / quotient
  logic               rneg_q, rneg_d;     // negate remainder
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_up;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    signed_op = ~op[0];
    a_mag = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // Shift-add step: add the multiplicand when the current multiplier bit is 1, then
    // shift right. The carry lands in the top bit.
    mul_addend = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Restoring step: shift left by one and subtract the divisor when it fits.
    // The remainder is always below 2^WIDTH, so the difference fits in WIDTH bits.
    div_up   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_up >= {1'b0, opnd_q});
    div_diff = div_up[WIDTH-1:0] - opnd_q;

    if (is_div_q) begin
      step = {(div_ge ? div_diff : div_up[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod_fix = neg_q  ? -step : step;
    quot_fix = neg_q  ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem_fix  = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d  = S_RUN;
              cnt_d    = '0;
              dbz_d    = 1'b0;
              is_div_d = op[1];
              neg_d    = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              rneg_d   = signed_op & src_a[WIDTH-1] & op[1];
              dz_d     = op[1] & (src_b == '0);
              if (op[1]) begin
                opnd_d = b_mag;
                // A zero divisor returns the raw dividend in HI, so keep it unmodified.
                acc_d  = {{WIDTH{1'b0}}, ((src_b == '0) ? src_a : a_mag)};
              end else begin
                opnd_d = a_mag;
                acc_d  = {{WIDTH{1'b0}}, b_mag};
              end
            end
            OP_MTHI: begin
              hi_d  = src_a;
              dbz_d = 1'b0;
            end
            OP_MTLO: begin
              lo_d  = src_a;
              dbz_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (dz_q) begin
          state_d = S_IDLE;
          lo_d    = {WIDTH{1'b1}};
          hi_d    = acc_q[WIDTH-1:0];
          dbz_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
              lo_d = quot_fix;
              hi_d = rem_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         cancel;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;   // bench's own record of what HI/LO should hold

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference results from plain wide integer arithmetic.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    rdz = 1'b0; rh = '0; rl = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb; {rh, rl} = p; end
      3'd1: begin up = ua * ub; {rh, rl} = up; end
      default: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = a; rdz = 1'b1;
        end else if (o == 3'd2) begin
          p = sa / sb; rl = p[31:0];
          p = sa % sb; rh = p[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int elat);
    int n;
    bit seen;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    chk({nm, " busy after E0"}, busy, 1);
    chk({nm, " dbz after E0"}, div_by_zero, 0);
    n = 0; seen = 0;
    while (!seen && n < W + 8) begin
      tick;
      n++;
      if (done) seen = 1;
    end
    chk({nm, " latency"}, 64'(n), 64'(elat));
    chk({nm, " busy at done"}, busy, 0);
    chk({nm, " hi"}, hi, ehi);
    chk({nm, " lo"}, lo, elo);
    chk({nm, " dbz"}, div_by_zero, edz);
    tick;
    chk({nm, " done single"}, done, 0);
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    logic [31:0] rh, rl;
    logic        rdz;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          n, dones;
    bit          seen;

    tbl[0]  = '{3'd1, 32'd123,        32'd456,        32'h0000_0000, 32'h0000_DB18, 1'b0, 32};
    tbl[1]  = '{3'd0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32};
    tbl[2]  = '{3'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32};
    tbl[3]  = '{3'd3, 32'd7,          32'd0,          32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 1};
    tbl[4]  = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0, 32};
    tbl[5]  = '{3'd0, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, 32};
    tbl[6]  = '{3'd2, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 32};
    tbl[7]  = '{3'd3, 32'hFFFF_FFFF,  32'd10,         32'h0000_0005, 32'h1999_9999, 1'b0, 32};
    tbl[8]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32};
    tbl[9]  = '{3'd2, 32'd0,          32'd5,          32'h0000_0000, 32'h0000_0000, 1'b0, 32};
    tbl[10] = '{3'd2, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 1};

    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    tick; tick;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", div_by_zero, 0);
    reset = 1'b1;
    tick;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($signed(5'($urandom_range(0, 31))));
      ref_model(ro, ra, rb, rh, rl, rdz);
      run_op($sformatf("rand%0d", i), ro, ra, rb, rh, rl, rdz, rdz ? 1 : W);
    end

    // Sticky divide-by-zero, cleared by the next accepted MULT.
    run_op("dz sticky", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1);
    tick; tick;
    chk("dbz sticky", div_by_zero, 1);
    run_op("dz clear", 3'd0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, W);

    // MTLO / MTHI single cycle.
    start = 1'b1; op = 3'd5; src_a = 32'hCAFE_BABE;
    tick; start = 1'b0;
    chk("mtlo lo", lo, 32'hCAFE_BABE);
    chk("mtlo busy", busy, 0);
    chk("mtlo done", done, 0);
    start = 1'b1; op = 3'd4; src_a = 32'h1234_5678;
    tick; start = 1'b0;
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi lo kept", lo, 32'hCAFE_BABE);
    m_hi = 32'h1234_5678; m_lo = 32'hCAFE_BABE;

    // No-op code and cancel in IDLE.
    start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF;
    tick; start = 1'b0;
    chk("noop busy", busy, 0);
    chk("noop hi", hi, m_hi);
    cancel = 1'b1;
    tick; cancel = 1'b0;
    chk("idle cancel busy", busy, 0);
    chk("idle cancel lo", lo, m_lo);

    // MTHI and MULTU starts while busy are ignored; the first op finishes on time.
    start = 1'b1; op = 3'd1; src_a = 32'd123; src_b = 32'd456;
    tick; start = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < W + 8) begin
      if (n == 2) begin start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF; end
      else if (n == 5) begin start = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9; end
      else start = 1'b0;
      tick;
      n++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("busy-start latency", 64'(n), 64'(W));
    chk("busy-start hi", hi, 32'd0);
    chk("busy-start lo", lo, 32'h0000_DB18);
    m_hi = 32'd0; m_lo = 32'h0000_DB18;
    tick;

    // Cancel at cycle 10 of a MULTU.
    start = 1'b1; op = 3'd1; src_a = 32'hFFFF_0000; src_b = 32'h0001_FFFF;
    tick; start = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    cancel = 1'b1;
    tick; cancel = 1'b0;
    chk("cancel10 busy", busy, 0);
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin tick; if (done) dones++; end
    chk("cancel10 no done", 64'(dones), 0);
    chk("cancel10 hi", hi, m_hi);
    chk("cancel10 lo", lo, m_lo);

    // Cancel on the final edge wins.
    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    tick; start = 1'b0;
    for (int i = 0; i < W - 1; i++) tick;
    chk("final cancel busy before", busy, 1);
    cancel = 1'b1;
    tick; cancel = 1'b0;
    chk("final cancel busy", busy, 0);
    chk("final cancel done", done, 0);
    chk("final cancel lo", lo, m_lo);
    tick;
    chk("final cancel done later", done, 0);

    // Start together with cancel while busy: abort, start dropped.
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
    tick; start = 1'b0;
    tick; tick; tick;
    start = 1'b1; op = 3'd1; src_a = 32'd2; src_b = 32'd3; cancel = 1'b1;
    tick; start = 1'b0; cancel = 1'b0;
    chk("start+cancel busy", busy, 0);
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin tick; if (done) dones++; end
    chk("start+cancel no done", 64'(dones), 0);
    chk("start+cancel hi", hi, m_hi);
    chk("start+cancel lo", lo, m_lo);

    // Asynchronous reset in the middle of a DIV.
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd7;
    tick; start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    #2 reset = 1'b0;
    #1;
    chk("async reset hi", hi, 0);
    chk("async reset lo", lo, 0);
    chk("async reset busy", busy, 0);
    chk("async reset done", done, 0);
    @(posedge clk); #1 reset = 1'b1;
    tick;
    chk("after reset busy", busy, 0);
    run_op("post reset", 3'd2, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, W);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
